// File: rtl/rd_cmd_arbiter.sv
// Round-robin arbiter sharing one packet-buffer read port among NPORT read
// channels: credit-limited word reads, return FIFO, per-packet last marker.
module rd_cmd_arbiter #(
  parameter int unsigned NPORT      = 4,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [NPORT-1:0]          iCmdVld,
  output logic [NPORT-1:0]          oCmdRdy,
  input  logic [NPORT*(ADDR_W+5)-1:0] iCmdPld,
  output logic                      oMemRdVld,
  output logic [ADDR_W-1:0]         oMemRdAddr,
  input  logic                      iMemRdRdy,
  input  logic                      iMemRdDataVld,
  input  logic [DATA_W-1:0]         iMemRdData,
  output logic [NPORT-1:0]          oRdDataVld,
  output logic [DATA_W-1:0]         oRdData,
  output logic                      oRdLast,
  input  logic [NPORT-1:0]          iRdDataRdy,
  output logic                      oBusy,
  output logic                      oErr
);
  localparam int unsigned CMD_W = ADDR_W + 5;
  localparam int unsigned PTR_W = $clog2(NPORT);
  localparam int unsigned FA_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = FA_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          len_q, len_d;
  logic [3:0]          issue_cnt_q, issue_cnt_d;
  logic [3:0]          pop_cnt_q, pop_cnt_d;
  logic [CNT_W-1:0]    outst_q, outst_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [FA_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FA_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

  logic                gnt_found;
  logic [PTR_W-1:0]    gnt_idx;
  int unsigned         cand;
  logic [CMD_W-1:0]    gnt_pld;
  logic                gnt_drop;
  logic [3:0]          gnt_len;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                cmd_hs, credit_ok, mem_hs, resp_ok, rd_vld, pop, last, pkt_end;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == NPORT - 1) ptr_inc = '0;
    else                     ptr_inc = p + PTR_W'(1);
  endfunction

  // Round-robin search: first valid channel at or after rr_ptr_q, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NPORT) cand = cand - NPORT;
      if (!gnt_found && iCmdVld[PTR_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(cand);
      end
    end
  end

  assign gnt_pld  = iCmdPld[32'(gnt_idx)*CMD_W +: CMD_W];
  assign gnt_drop = gnt_pld[0];
  assign gnt_len  = gnt_pld[4:1];
  assign gnt_addr = gnt_pld[CMD_W-1:5];

  assign cmd_hs    = (state_q == S_IDLE) && gnt_found;
  assign credit_ok = (SUM_W'(outst_q) + SUM_W'(fifo_cnt_q)) < SUM_W'(FIFO_DEPTH);
  assign mem_hs    = oMemRdVld && iMemRdRdy;
  assign resp_ok   = iMemRdDataVld && (outst_q != '0);
  assign rd_vld    = (fifo_cnt_q != '0) && (state_q != S_IDLE);
  assign pop       = rd_vld && iRdDataRdy[gnt_q];
  assign last      = (pop_cnt_q == len_q);
  assign pkt_end   = pop && last;

  always_ff @(posedge iClk) begin
    if (iRst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_hs && !gnt_drop)                  state_d = S_ISSUE;
      S_ISSUE: if (mem_hs && (issue_cnt_q == len_q))     state_d = S_DRAIN;
      S_DRAIN: if (pkt_end)                              state_d = S_IDLE;
      default:                                           state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oCmdRdy    = '0;
    oMemRdVld  = 1'b0;
    oRdDataVld = '0;
    oRdLast    = 1'b0;
    oBusy      = (state_q != S_IDLE);
    if (cmd_hs) oCmdRdy[gnt_idx] = 1'b1;
    if ((state_q == S_ISSUE) && credit_ok) oMemRdVld = 1'b1;
    if (rd_vld) begin
      oRdDataVld[gnt_q] = 1'b1;
      oRdLast           = last;
    end
  end

  assign oMemRdAddr = addr_q + ADDR_W'(issue_cnt_q);
  assign oRdData    = fifo_mem_q[rd_ptr_q];
  assign oErr       = err_q;

  // Datapath next-state; the credit rule keeps outstanding+fifo within depth.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_d       = err_q;
    if (cmd_hs) begin
      addr_d      = gnt_addr;
      len_d       = gnt_len;
      gnt_d       = gnt_idx;
      issue_cnt_d = '0;
      pop_cnt_d   = '0;
      if (gnt_drop) rr_ptr_d = ptr_inc(gnt_idx);
    end
    if (mem_hs) issue_cnt_d = issue_cnt_q + 4'd1;
    if (pop) begin
      pop_cnt_d = pop_cnt_q + 4'd1;
      rd_ptr_d  = rd_ptr_q + FA_W'(1);
    end
    if (pkt_end) rr_ptr_d = ptr_inc(gnt_q);
    if (resp_ok) wr_ptr_d = wr_ptr_q + FA_W'(1);
    if (iMemRdDataVld && (outst_q == '0)) err_d = 1'b1;
    outst_d    = outst_q + CNT_W'(mem_hs) - CNT_W'(resp_ok);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(resp_ok) - CNT_W'(pop);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      outst_q     <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      outst_q     <= outst_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
    end
  end

  // Return-data storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge iClk) begin
    if (resp_ok) fifo_mem_q[wr_ptr_q] <= iMemRdData;
  end

endmodule

// File: tb/tb_rd_cmd_arbiter.sv
// Scoreboard bench for rd_cmd_arbiter: a round-robin reference model queues
// expected grants, read addresses and beats; a negedge monitor checks them.
module tb_rd_cmd_arbiter;
  localparam int unsigned NPORT  = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CMD_W  = ADDR_W + 5;
  localparam int          TMO    = 3000;

  logic                      iClk = 1'b0;
  logic                      iRst;
  logic [NPORT-1:0]          iCmdVld;
  logic [NPORT-1:0]          oCmdRdy;
  logic [NPORT*CMD_W-1:0]    iCmdPld;
  logic                      oMemRdVld;
  logic [ADDR_W-1:0]         oMemRdAddr;
  logic                      iMemRdRdy;
  logic                      iMemRdDataVld;
  logic [DATA_W-1:0]         iMemRdData;
  logic [NPORT-1:0]          oRdDataVld;
  logic [DATA_W-1:0]         oRdData;
  logic                      oRdLast;
  logic [NPORT-1:0]          iRdDataRdy;
  logic                      oBusy;
  logic                      oErr;

  rd_cmd_arbiter #(.NPORT(NPORT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .iClk(iClk), .iRst(iRst), .iCmdVld(iCmdVld), .oCmdRdy(oCmdRdy), .iCmdPld(iCmdPld),
    .oMemRdVld(oMemRdVld), .oMemRdAddr(oMemRdAddr), .iMemRdRdy(iMemRdRdy),
    .iMemRdDataVld(iMemRdDataVld), .iMemRdData(iMemRdData), .oRdDataVld(oRdDataVld),
    .oRdData(oRdData), .oRdLast(oRdLast), .iRdDataRdy(iRdDataRdy), .oBusy(oBusy), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  typedef struct { int port; bit drop; } gnt_t;
  typedef struct { int port; logic [DATA_W-1:0] data; bit last; } beat_t;

  gnt_t  exp_gnt_q[$];
  int    exp_addr_q[$];
  beat_t exp_beat_q[$];

  logic [DATA_W-1:0] mem_img [0:4095];
  logic [ADDR_W-1:0] c_addr [NPORT];
  logic [3:0]        c_len  [NPORT];
  bit                c_drop [NPORT];

  int n_chk = 0, n_pass = 0;
  int m_rr = 0;
  bit m_err = 0;
  int rdy_mode = 0, lat = 2, n_mem_acc = 0, inj_req = 0, inj_done = 0;
  bit mrdy_rand = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Reference model: resolve a batch of simultaneous requests in round-robin order.
  task automatic model_batch(input logic [NPORT-1:0] mask);
    bit pend[NPORT];
    int p = m_rr;
    for (int k = 0; k < NPORT; k++) pend[k] = mask[k];
    for (int n = 0; n < NPORT; n++) begin
      int g = -1;
      for (int i = 0; i < NPORT; i++) begin
        int c = (p + i) % NPORT;
        if (g < 0 && pend[c]) g = c;
      end
      if (g < 0) break;
      pend[g] = 0;
      exp_gnt_q.push_back('{port: g, drop: c_drop[g]});
      if (!c_drop[g]) begin
        for (int b = 0; b <= int'(c_len[g]); b++) begin
          int a = (int'(c_addr[g]) + b) % 4096;
          exp_addr_q.push_back(a);
          exp_beat_q.push_back('{port: g, data: mem_img[a], last: (b == int'(c_len[g]))});
        end
      end
      p = (g + 1) % NPORT;
    end
    m_rr = p;
  endtask

  task automatic drive_batch(input logic [NPORT-1:0] mask);
    logic [NPORT-1:0] hs;
    int t = 0;
    @(posedge iClk); #1;
    for (int k = 0; k < NPORT; k++) iCmdPld[k*CMD_W +: CMD_W] = {c_addr[k], c_len[k], c_drop[k]};
    iCmdVld = mask;
    while (iCmdVld != '0 && t < 500) begin
      @(negedge iClk);
      hs = iCmdVld & oCmdRdy;
      @(posedge iClk); #1;
      iCmdVld = iCmdVld & ~hs;
      for (int k = 0; k < NPORT; k++)
        if (hs[k]) iCmdPld[k*CMD_W +: CMD_W] = CMD_W'($urandom);
      t++;
    end
    chk("cmd_accept", iCmdVld == '0, 64'(iCmdVld), 64'(0));
    iCmdVld = '0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((exp_beat_q.size() != 0 || exp_addr_q.size() != 0 || exp_gnt_q.size() != 0 || oBusy) && t < TMO) begin
      @(negedge iClk);
      t++;
    end
    chk(name, t < TMO, 64'(exp_beat_q.size()), 64'(0));
    if (t >= TMO) begin
      exp_beat_q.delete(); exp_addr_q.delete(); exp_gnt_q.delete();
    end
  endtask

  task automatic run(input logic [NPORT-1:0] mask, input string name);
    model_batch(mask);
    drive_batch(mask);
    wait_done(name);
  endtask

  task automatic set_cmd(input int k, input int a, input int l, input bit d);
    c_addr[k] = ADDR_W'(a);
    c_len[k]  = 4'(l);
    c_drop[k] = d;
  endtask

  // Memory model: fixed-latency in-order responder plus stray-response injector.
  bit                pv [0:15];
  logic [DATA_W-1:0] pd [0:15];
  initial begin
    bit acc;
    int aa;
    iMemRdRdy = 1'b1; iMemRdDataVld = 1'b0; iMemRdData = '0;
    for (int i = 0; i < 16; i++) begin pv[i] = 0; pd[i] = '0; end
    forever begin
      @(negedge iClk);
      acc = oMemRdVld && iMemRdRdy && !iRst;
      aa  = int'(oMemRdAddr);
      @(posedge iClk); #1;
      for (int i = 0; i < 15; i++) begin pv[i] = pv[i+1]; pd[i] = pd[i+1]; end
      pv[15] = 0;
      if (acc) begin pv[lat-1] = 1; pd[lat-1] = mem_img[aa]; end
      if (iRst) for (int i = 0; i < 16; i++) pv[i] = 0;
      iMemRdDataVld = pv[0];
      iMemRdData    = pv[0] ? pd[0] : DATA_W'($urandom);
      if (inj_req != inj_done) begin
        iMemRdDataVld = 1'b1;
        iMemRdData    = DATA_W'($urandom);
        inj_done++;
      end
      iMemRdRdy = mrdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    iRdDataRdy = '1;
    forever begin
      @(posedge iClk); #1;
      case (rdy_mode)
        0:       iRdDataRdy = '1;
        1:       iRdDataRdy = NPORT'($urandom);
        default: iRdDataRdy = '0;
      endcase
    end
  end

  // Monitor: compares DUT activity against the queued expectations.
  int outst = 0, fcnt = 0;
  bit f_busy_lo = 0, f_memvld = 0, f_rdvld = 0, f_next_gnt = 0;
  always @(negedge iClk) begin
    logic [NPORT-1:0] hs, pv_hs;
    int gi, pi;
    gnt_t g;
    beat_t e;
    int ea;
    if (iRst) begin
      m_err = 0; outst = 0; fcnt = 0;
      f_busy_lo = 0; f_memvld = 0; f_rdvld = 0; f_next_gnt = 0;
    end else begin
      if (f_busy_lo) chk("busy_after_last", !oBusy, 64'(oBusy), 64'(0));
      if (f_memvld) chk("memvld_after_cmd", oMemRdVld, 64'(oMemRdVld), 64'(1));
      if (f_rdvld) chk("rdvld_after_resp", oRdDataVld != '0, 64'(oRdDataVld), 64'(1));
      if (f_next_gnt) chk("gnt_after_drop", (oCmdRdy & iCmdVld) != '0, 64'(oCmdRdy), 64'(iCmdVld));
      f_busy_lo = 0; f_memvld = 0; f_rdvld = 0; f_next_gnt = 0;
      chk("oErr", oErr == m_err, 64'(oErr), 64'(m_err));
      chk("credit", outst + fcnt <= int'(DEPTH), 64'(outst + fcnt), 64'(DEPTH));
      chk("cmdrdy_onehot", $onehot0(oCmdRdy), 64'(oCmdRdy), 64'(0));
      hs = oCmdRdy & iCmdVld;
      if (hs != '0) begin
        gi = 0;
        for (int k = NPORT - 1; k >= 0; k--) if (hs[k]) gi = k;
        if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 0, 64'(gi), 64'(0));
        else begin
          g = exp_gnt_q.pop_front();
          chk("gnt_port", gi == g.port, 64'(gi), 64'(g.port));
          if (!g.drop) f_memvld = 1;
          else if ((iCmdVld & ~hs) != '0) f_next_gnt = 1;
        end
      end
      if (iMemRdDataVld) begin
        if (outst == 0) m_err = 1;
        else begin outst--; fcnt++; f_rdvld = 1; end
      end
      if (oMemRdVld && iMemRdRdy) begin
        n_mem_acc++;
        outst++;
        if (exp_addr_q.size() == 0) chk("rd_unexpected", 0, 64'(oMemRdAddr), 64'(0));
        else begin
          ea = exp_addr_q.pop_front();
          chk("rd_addr", int'(oMemRdAddr) == ea, 64'(oMemRdAddr), 64'(ea));
        end
      end
      chk("rdvld_onehot", $onehot0(oRdDataVld), 64'(oRdDataVld), 64'(0));
      pv_hs = oRdDataVld & iRdDataRdy;
      if (pv_hs != '0) begin
        pi = 0;
        for (int k = NPORT - 1; k >= 0; k--) if (pv_hs[k]) pi = k;
        fcnt--;
        if (exp_beat_q.size() == 0) chk("beat_unexpected", 0, 64'(oRdData), 64'(0));
        else begin
          e = exp_beat_q.pop_front();
          chk("beat_port", pi == e.port, 64'(pi), 64'(e.port));
          chk("beat_data", oRdData == e.data, 64'(oRdData), 64'(e.data));
          chk("beat_last", oRdLast == e.last, 64'(oRdLast), 64'(e.last));
          if (e.last) f_busy_lo = 1;
        end
      end
    end
  end

  initial begin
    int base;
    logic [NPORT-1:0] m;
    for (int i = 0; i < 4096; i++) mem_img[i] = DATA_W'($urandom);
    for (int k = 0; k < NPORT; k++) set_cmd(k, 0, 0, 0);
    iRst = 1'b1; iCmdVld = '0; iCmdPld = '0;
    repeat (3) @(posedge iClk);
    #2 iRst = 1'b0;
    @(negedge iClk);
    chk("rst_cmdrdy", oCmdRdy == '0, 64'(oCmdRdy), 64'(0));
    chk("rst_memvld", !oMemRdVld, 64'(oMemRdVld), 64'(0));
    chk("rst_rdvld", oRdDataVld == '0, 64'(oRdDataVld), 64'(0));
    chk("rst_last", !oRdLast, 64'(oRdLast), 64'(0));
    chk("rst_busy", !oBusy, 64'(oBusy), 64'(0));
    chk("rst_err", !oErr, 64'(oErr), 64'(0));

    // Single packet, four beats from 0x010.
    lat = 2;
    set_cmd(0, 'h010, 3, 0);
    run(4'b0001, "single_pkt");

    // Round-robin: realign pointer to 0 with a drop, then all four channels.
    set_cmd(3, 0, 0, 1);
    run(4'b1000, "drop_align0");
    for (int k = 0; k < NPORT; k++) set_cmd(k, int'($urandom_range(0, 4095)), 0, 0);
    run(4'b1111, "rr_all_from0");
    run(4'b0001, "rr_wrap_to0");
    set_cmd(1, 0, 0, 1);
    run(4'b0010, "drop_align2");
    for (int k = 0; k < NPORT; k++) set_cmd(k, int'($urandom_range(0, 4095)), 0, 0);
    run(4'b1111, "rr_all_from2");

    // Drop on channel 1 followed immediately by channel 2.
    set_cmd(0, 0, 0, 1);
    run(4'b0001, "drop_align1");
    set_cmd(1, 'h123, 5, 1);
    set_cmd(2, 'h200, 1, 0);
    run(4'b0110, "drop_then_next");

    // Backpressure: reads stop at FIFO depth until the channel is ready.
    lat = 3;
    rdy_mode = 2;
    set_cmd(0, 'h300, 15, 0);
    base = n_mem_acc;
    model_batch(4'b0001);
    drive_batch(4'b0001);
    repeat (20) @(negedge iClk);
    chk("stall_reads", n_mem_acc - base == int'(DEPTH), 64'(n_mem_acc - base), 64'(DEPTH));
    chk("stall_memvld", !oMemRdVld, 64'(oMemRdVld), 64'(0));
    chk("stall_beats_held", exp_beat_q.size() == 16, 64'(exp_beat_q.size()), 64'(16));
    rdy_mode = 0;
    wait_done("stall_release");

    // Address wrap.
    lat = 2;
    set_cmd(0, 'hFFE, 3, 0);
    run(4'b0001, "addr_wrap");

    // Stray response while idle sets a sticky error.
    inj_req++;
    repeat (6) @(negedge iClk);
    chk("err_sticky", oErr, 64'(oErr), 64'(1));

    // Reset in the middle of a packet.
    rdy_mode = 2;
    set_cmd(2, 'h456, 15, 0);
    model_batch(4'b0100);
    drive_batch(4'b0100);
    repeat (5) @(negedge iClk);
    @(posedge iClk); #2;
    iRst = 1'b1;
    exp_gnt_q.delete(); exp_addr_q.delete(); exp_beat_q.delete();
    @(posedge iClk); #2;
    iRst = 1'b0;
    m_rr = 0;
    rdy_mode = 0;
    @(negedge iClk);
    chk("midrst_err", !oErr, 64'(oErr), 64'(0));
    chk("midrst_busy", !oBusy, 64'(oBusy), 64'(0));
    chk("midrst_rdvld", oRdDataVld == '0, 64'(oRdDataVld), 64'(0));
    for (int k = 0; k < NPORT; k++) set_cmd(k, int'($urandom_range(0, 4095)), 0, 0);
    run(4'b1111, "rr_after_reset");

    // Randomized batches.
    for (int n = 0; n < 30; n++) begin
      lat       = int'($urandom_range(1, 6));
      rdy_mode  = int'($urandom_range(0, 1));
      mrdy_rand = bit'($urandom_range(0, 1));
      m = NPORT'($urandom_range(1, 15));
      for (int k = 0; k < NPORT; k++)
        set_cmd(k, int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      run(m, "rand_batch");
    end

    repeat (3) @(negedge iClk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
